// File: rtl/mem_ctrl_be.sv
// rtl/mem_ctrl_be.sv - single-port byte-enable word memory with init sequencer and pipelined reads
//
// Purpose:
//   Word memory behind a valid/ready request port. Writes honour per-byte
//   enables and complete in one cycle (wr_ack/wr_err). Reads sample the array
//   at acceptance and return through a READ_LAT-cycle pipeline. After reset,
//   or on init_start, the array is cleared one word per cycle while busy = 1.
//   Out-of-range addresses (>= DEPTH) are flagged instead of touching memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (req_ready is combinational)
//   req_wr, req_addr           1 = write / 0 = read, word address
//   req_wdata, req_be          write data and byte enables
//   init_start                 pulse to re-clear the memory (ignored while busy)
//   busy                       clear sequence in progress
//   rsp_valid, rsp_data,       read response pulse, data (held between pulses),
//   rsp_err                    out-of-range flag
//   wr_ack, wr_err             write completion pulse and out-of-range flag

module mem_ctrl_be #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int READ_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic                    init_start,
    output logic                    busy,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    wr_ack,
    output logic                    wr_err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        init_idx_q, init_idx_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Read pipeline: stage 0 is loaded on the accepting edge, the response
    // registers after READ_LAT further edges.
    logic                    pipe_valid_q [READ_LAT];
    logic                    pipe_valid_d [READ_LAT];
    logic                    pipe_err_q   [READ_LAT];
    logic                    pipe_err_d   [READ_LAT];
    logic [DATA_WIDTH-1:0]   pipe_data_q  [READ_LAT];
    logic [DATA_WIDTH-1:0]   pipe_data_d  [READ_LAT];

    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic                    wr_ack_q,    wr_ack_d;
    logic                    wr_err_q,    wr_err_d;

    logic                    accept;
    logic                    in_range;
    logic [IDX_W-1:0]        req_idx;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic                    mem_we;
    logic [IDX_W-1:0]        mem_widx;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [BE_W-1:0]         mem_wbe;

    // init_start wins over a request presented in the same cycle.
    assign req_ready = (state_q == ST_READY) && !init_start;
    assign busy      = (state_q == ST_INIT);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);
    assign req_idx   = req_addr[IDX_W-1:0];
    assign rd_data   = in_range ? mem[req_idx] : '0;

    // State / init counter
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + IDX_W'(1);
                if (init_idx_q == LAST_IDX) begin
                    state_d    = ST_READY;
                    init_idx_d = '0;
                end
            end
            ST_READY: begin
                if (init_start) begin
                    state_d    = ST_INIT;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    // Array write port, shared by the clear sequencer and bus writes
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = init_idx_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        if (state_q == ST_INIT) begin
            mem_we = 1'b1;
        end else if (accept && req_wr && in_range) begin
            mem_we    = 1'b1;
            mem_widx  = req_idx;
            mem_wdata = req_wdata;
            mem_wbe   = req_be;
        end
    end

    // Read pipeline and response/ack registers
    always_comb begin
        pipe_valid_d[0] = accept && !req_wr;
        pipe_err_d[0]   = !in_range;
        pipe_data_d[0]  = rd_data;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_err_d[i]   = pipe_err_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end

        rsp_valid_d = pipe_valid_q[READ_LAT-1];
        rsp_err_d   = pipe_valid_q[READ_LAT-1] && pipe_err_q[READ_LAT-1];
        // Data holds between responses.
        rsp_data_d  = pipe_valid_q[READ_LAT-1] ? pipe_data_q[READ_LAT-1] : rsp_data_q;

        wr_ack_d    = accept && req_wr;
        wr_err_d    = accept && req_wr && !in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_err_q[i]   <= 1'b0;
                pipe_data_q[i]  <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_err_q[i]   <= pipe_err_d[i];
                pipe_data_q[i]  <= pipe_data_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Storage has no reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_mem_ctrl_be.sv
// tb/tb_mem_ctrl_be.sv - self-checking bench for mem_ctrl_be at read latencies 1, 2 and 4
module tb_mem_ctrl_be;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NDUT  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          init_start = 1'b0;

    logic          req_ready_w [NDUT];
    logic          busy_w      [NDUT];
    logic          rsp_valid_w [NDUT];
    logic [DW-1:0] rsp_data_w  [NDUT];
    logic          rsp_err_w   [NDUT];
    logic          wr_ack_w    [NDUT];
    logic          wr_err_w    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        mem_ctrl_be #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .DEPTH     (DEPTH),
            .READ_LAT  (LAT)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready_w[g]),
            .req_wr    (req_wr),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .req_be    (req_be),
            .init_start(init_start),
            .busy      (busy_w[g]),
            .rsp_valid (rsp_valid_w[g]),
            .rsp_data  (rsp_data_w[g]),
            .rsp_err   (rsp_err_w[g]),
            .wr_ack    (wr_ack_w[g]),
            .wr_err    (wr_err_w[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    // Reference model
    int            n_tests = 0;
    int            n_fail  = 0;
    int            edge_cnt;
    int            init_left;
    logic [DW-1:0] ref_mem [DEPTH];
    logic          hist_v [16];
    logic          hist_e [16];
    logic [DW-1:0] hist_d [16];
    logic          exp_wr_ack;
    logic          exp_wr_err;
    logic [DW-1:0] last_data [NDUT];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_cnt   = 0;
        init_left  = DEPTH;
        exp_wr_ack = 1'b0;
        exp_wr_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hist_v[i] = 1'b0;
            hist_e[i] = 1'b0;
            hist_d[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int g = 0; g < NDUT; g++) last_data[g] = '0;
    endtask

    task automatic check_reset_values();
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("rst req_ready L%0d", lat_of(g)), req_ready_w[g], 1'b0);
            check_eq($sformatf("rst busy L%0d", lat_of(g)),      busy_w[g],      1'b1);
            check_eq($sformatf("rst rsp_valid L%0d", lat_of(g)), rsp_valid_w[g], 1'b0);
            check_eq($sformatf("rst rsp_data L%0d", lat_of(g)),  rsp_data_w[g],  '0);
            check_eq($sformatf("rst rsp_err L%0d", lat_of(g)),   rsp_err_w[g],   1'b0);
            check_eq($sformatf("rst wr_ack L%0d", lat_of(g)),    wr_ack_w[g],    1'b0);
            check_eq($sformatf("rst wr_err L%0d", lat_of(g)),    wr_err_w[g],    1'b0);
        end
    endtask

    // Called #1 after a posedge. Holds reset over several edges, checking that
    // nothing leaks out, then releases it away from the clock edge.
    task automatic do_reset(input int cycles);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        init_start = 1'b0;
        #1;
        check_reset_values();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_reset_values();
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    // One clock: present inputs, check req_ready, advance the model over the
    // edge, then check registered outputs after the edge.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be, input logic init);
        logic rdy;
        int   slot;
        int   ps;
        req_valid  = v;
        req_wr     = w;
        req_addr   = a;
        req_wdata  = d;
        req_be     = be;
        init_start = init;
        #1;
        rdy = (init_left == 0) && !init;
        for (int g = 0; g < NDUT; g++)
            check_eq($sformatf("req_ready L%0d", lat_of(g)), req_ready_w[g], rdy);

        edge_cnt++;
        slot = edge_cnt & 15;
        hist_v[slot] = 1'b0;
        hist_e[slot] = 1'b0;
        hist_d[slot] = '0;
        exp_wr_ack   = 1'b0;
        exp_wr_err   = 1'b0;
        if (v && rdy) begin
            if (w) begin
                exp_wr_ack = 1'b1;
                if (int'(a) >= DEPTH) exp_wr_err = 1'b1;
                else
                    for (int k = 0; k < 4; k++)
                        if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
            end else begin
                hist_v[slot] = 1'b1;
                if (int'(a) >= DEPTH) hist_e[slot] = 1'b1;
                else hist_d[slot] = ref_mem[a];
            end
        end
        if (init_left > 0) begin
            init_left--;
        end else if (init) begin
            // Whole memory reads as zero once the sequence completes; no read
            // can be accepted before then, so clear the model at once.
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end

        @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            ps = (edge_cnt - lat_of(g)) & 15;
            check_eq($sformatf("busy L%0d", lat_of(g)),   busy_w[g],   (init_left > 0));
            check_eq($sformatf("wr_ack L%0d", lat_of(g)), wr_ack_w[g], exp_wr_ack);
            check_eq($sformatf("wr_err L%0d", lat_of(g)), wr_err_w[g], exp_wr_err);
            check_eq($sformatf("rsp_valid L%0d", lat_of(g)), rsp_valid_w[g], hist_v[ps]);
            if (hist_v[ps]) begin
                last_data[g] = hist_d[ps];
                check_eq($sformatf("rsp_err L%0d", lat_of(g)), rsp_err_w[g], hist_e[ps]);
            end
            check_eq($sformatf("rsp_data L%0d", lat_of(g)), rsp_data_w[g], last_data[g]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
        step(1'b1, 1'b1, AW'(a), d, be, 1'b0);
    endtask

    task automatic rd(input int a);
        step(1'b1, 1'b0, AW'(a), DW'($urandom), 4'($urandom), 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int a;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Clear sequence after reset, then every word reads zero
        idle(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(5);

        // Byte-enable merge
        wr(5, 32'hDEADBEEF, 4'hF);
        wr(5, 32'h00001200, 4'h2);
        rd(5);
        idle(5);
        wr(6, 32'hCAFEF00D, 4'h0);
        rd(6);
        idle(5);

        // Streamed reads in order
        for (int i = 0; i < 8; i++) wr(i, DW'(i * 3), 4'hF);
        for (int i = 0; i < 8; i++) rd(i);
        idle(5);

        // Read directly after write to the same word
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            wr(a, $urandom, 4'($urandom));
            rd(a);
        end
        idle(5);

        // Out of range
        wr(40, 32'h12345678, 4'hF);
        rd(40);
        rd(8);
        wr(DEPTH, 32'h1, 4'hF);
        rd(DEPTH - 1);
        rd(63);
        idle(5);

        // Random traffic, occasionally re-clearing
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 39)),
                 $urandom, 4'($urandom), ($urandom_range(0, 79) == 0));
        end
        idle(DEPTH + 5);

        // init_start with a request while two reads are in flight
        wr(3, 32'h11112222, 4'hF);
        wr(4, 32'h33334444, 4'hF);
        rd(3);
        rd(4);
        step(1'b1, 1'b0, AW'(3), '0, 4'h0, 1'b1);
        idle(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(5);

        // Reset while reads are in flight
        wr(7, 32'hA5A5A5A5, 4'hF);
        rd(7);
        rd(7);
        rd(7);
        do_reset(3);
        idle(DEPTH + 2);
        rd(7);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_be.md
# mem_ctrl_be

Parametrised single-port word memory with a valid/ready request interface, per-byte write enables, and a configurable pipelined read latency. Memory is cleared by a hardware init sequencer after reset or on command, and out-of-range accesses are flagged. It sits between a bus-side master or sequencer and local storage, and replaces the fixed 16x32 en/wr memory.

## Interface
Parameters:
- ADDR_WIDTH, 5: request address width.
- DATA_WIDTH, 32: word width. Must be a multiple of 8.
- DEPTH, 32: number of words. Must satisfy DEPTH <= 2^ADDR_WIDTH.
- READ_LAT, 2: read latency in cycles. Legal range 1..4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte write enables; bit k covers bits [8k+7:8k].
- init_start  in  1  pulse to re-clear the whole memory.
- busy  out  1  init sequence in progress.
- rsp_valid  out  1  read response valid; one-cycle pulse per read.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_err  out  1  read address was out of range; qualified by rsp_valid.
- wr_ack  out  1  write completed; one-cycle pulse per write.
- wr_err  out  1  write address was out of range; qualified by wr_ack.

## Operation
- States:
  - INIT: clear one word per cycle using counter init_idx, 0..DEPTH-1.
  - READY: serve requests.
- State transitions:
  - Reset enters INIT with init_idx = 0.
  - INIT goes to READY after the edge that clears word DEPTH-1.
  - READY goes to INIT on init_start = 1. init_start is ignored while in INIT.
- Handshake:
  - req_ready = (state == READY) && !init_start. This is combinational; init_start has priority over a request in the same cycle.
  - A request is accepted on a rising edge where req_valid && req_ready.
- Write:
  - For each k, byte k of MEM[addr] is updated where req_be[k] = 1. Other bytes are unchanged.
  - req_be = 0 changes nothing but still acks.
  - wr_ack is high for the cycle after acceptance.
- Read:
  - Address and error flag enter a READ_LAT-deep pipeline.
  - Throughput is one read per cycle. There is no response backpressure.
- Out of range (req_addr >= DEPTH):
  - A write is discarded, and wr_ack is accompanied by wr_err = 1.
  - A read returns rsp_data = 0 with rsp_err = 1.
- busy = (state == INIT).
- Reads in flight when init_start is taken complete normally with the data sampled at acceptance.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - req_ready = 0, busy = 1.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - wr_ack = 0, wr_err = 0.
  - Read pipeline cleared; state = INIT, init_idx = 0.
  - Memory array is not reset directly; it is cleared by INIT.
- Init sequence:
  - The first rising edge after rst_n deasserts clears word 0. Edge n clears word n-1.
  - busy falls and req_ready rises after edge DEPTH, i.e. the memory is usable DEPTH cycles after reset release.
- Read latency:
  - A read accepted at edge N drives rsp_valid/rsp_data/rsp_err high after edge N+READ_LAT, for exactly one cycle.
  - Back-to-back reads give back-to-back responses in order.
- Write:
  - A write accepted at edge N updates memory at edge N.
  - wr_ack/wr_err are high during the cycle after edge N.
- Read-after-write: a read accepted at edge N+1 returns the data written at N.
- Reset asserted mid-operation:
  - All pending responses are dropped with no rsp_valid.
  - Outputs go to reset values immediately; INIT restarts from word 0.
- Non-accepted cycles: rsp_data holds its last value while rsp_valid = 0.

## Test plan
- Reset release, DEPTH=32: busy=1 for 32 cycles, then req_ready=1; reading all 32 addresses returns 0 with rsp_err=0.
- Write 0xDEADBEEF to addr 5 with be=0xF, then write 0x00001200 with be=0x2, then read addr 5 -> 0xDEAD12EF after exactly READ_LAT cycles. Repeat with READ_LAT=1 and READ_LAT=4.
- Read stream to addresses 0..7 on consecutive cycles after writing value=addr*3 -> 8 consecutive rsp_valid pulses with data 0,3,...,21 in order. Also a write at N followed by a read at N+1 to the same address -> returns the new data.
- Write to addr 40 with DEPTH=32 (ADDR_WIDTH=6) -> wr_ack=1 with wr_err=1 and no memory change; read addr 40 -> rsp_data=0, rsp_err=1.
- init_start together with req_valid while two reads are in flight -> request not accepted, both in-flight reads still respond with pre-init data, busy=1 for DEPTH cycles, then all words read 0.
- rst_n pulsed low while 3 reads are in flight -> no rsp_valid pulses, outputs at reset values, INIT restarts from word 0.
